sw_sample_ctrl: RTL and testbench

SW_SAMPLE_CTRL -- requirements
Module: sw_sample_ctrl

---
 rtl/sw_sample_ctrl.sv | 96 +++++++++
 tb/tb_sw_sample_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sw_sample_ctrl.sv
// Switch sampler: synchronizes raw switch levels, debounces the whole bus as one value, and
// commits each stable new value to the switch input buffer once, deferring while the CPU is loading.
module sw_sample_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WIDTH           = 32
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_sw_raw,
  input  logic             i_ld_req,
  input  logic             i_chg_clr,
  output logic             o_wren,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_changed,
  output logic [1:0]       o_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] comm_q, comm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic             changed_q, changed_d;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      comm_q    <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= i_sw_raw;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      comm_q    <= comm_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    comm_d    = comm_q;
    cnt_d     = cnt_q;
    changed_d = i_chg_clr ? 1'b0 : changed_q;
    case (state_q)
      IDLE: begin
        if (sync2_q != comm_q) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2_q == comm_q) begin
          state_d = IDLE;
        end else if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      COMMIT: begin
        // cand stays frozen until the buffer write lands; a commit wins over a same-cycle clear
        if (!i_ld_req) begin
          comm_d    = cand_q;
          changed_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_wren    = (state_q == COMMIT) && !i_ld_req;
  assign o_wdata   = cand_q;
  assign o_changed = changed_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_sw_sample_ctrl.sv
// Bench for sw_sample_ctrl: table of commit vectors plus hand sequences for glitch, toggle and reset-abort.
module tb_sw_sample_ctrl;

  logic        i_clk;
  logic        rst_n;
  logic [31:0] i_sw_raw;
  logic        i_ld_req;
  logic        i_chg_clr;
  logic        o_wren;
  logic [31:0] o_wdata;
  logic        o_changed;
  logic [1:0]  o_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  sw_sample_ctrl #(.DEBOUNCE_CYCLES(16), .WIDTH(32)) dut (
    .i_clk    (i_clk),
    .rst_n    (rst_n),
    .i_sw_raw (i_sw_raw),
    .i_ld_req (i_ld_req),
    .i_chg_clr(i_chg_clr),
    .o_wren   (o_wren),
    .o_wdata  (o_wdata),
    .o_changed(o_changed),
    .o_state  (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard: every buffer write must match the oldest outstanding expected value.
  always @(negedge i_clk) begin
    if (o_wren) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_wren act=%h exp=none t=%0t", o_wdata, $time);
      end else begin
        chk("sb_wdata", o_wdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] raw;
    int          ld_hold;
    bit          clr_at_commit;
    int          exp_wr_edge;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit seen_settle, seen_idle;

    vecs[0] = '{32'hA5A5_0001, 0, 1'b0, 20, 32'hA5A5_0001};
    vecs[1] = '{32'h8000_0000, 0, 1'b1, 20, 32'h8000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 7, 1'b0, 27, 32'hFFFF_FFFF};
    vecs[3] = '{32'h0000_0000, 2, 1'b1, 22, 32'h0000_0000};

    rst_n     = 1'b1;
    i_sw_raw  = 32'h0;
    i_ld_req  = 1'b0;
    i_chg_clr = 1'b0;
    #2 rst_n  = 1'b0;
    i_sw_raw  = 32'hDEAD_BEEF;
    #20;
    chk("rst_wren",    32'(o_wren),    32'd0);
    chk("rst_wdata",   o_wdata,        32'd0);
    chk("rst_changed", 32'(o_changed), 32'd0);
    chk("rst_state",   32'(o_state),   32'd0);
    i_sw_raw = 32'h0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", 32'(o_state), 32'd0);

    for (int v = 0; v < 4; v++) begin
      if (!vecs[v].clr_at_commit) begin
        i_chg_clr = 1'b1;
        tick();
        i_chg_clr = 1'b0;
        chk("vec_preclear", 32'(o_changed), 32'd0);
      end
      i_ld_req = (vecs[v].ld_hold > 0);
      i_sw_raw = vecs[v].raw;
      exp_q.push_back(vecs[v].exp_wdata);
      for (int t = 1; t <= vecs[v].exp_wr_edge; t++) begin
        tick();
        if (t >= vecs[v].exp_wr_edge - 1) i_ld_req = 1'b0;
        i_chg_clr = (t == vecs[v].exp_wr_edge - 1) && vecs[v].clr_at_commit;
        #1;
        if (t < vecs[v].exp_wr_edge)
          chk($sformatf("vec%0d_wren_e%0d", v, t), 32'(o_wren), 32'(t == vecs[v].exp_wr_edge - 1));
        if (t >= vecs[v].exp_wr_edge - 1 - vecs[v].ld_hold && t < vecs[v].exp_wr_edge) begin
          chk($sformatf("vec%0d_commit_state", v), 32'(o_state), 32'd2);
          chk($sformatf("vec%0d_wdata_hold", v), o_wdata, vecs[v].exp_wdata);
        end
        if (t == vecs[v].exp_wr_edge - 1)
          chk($sformatf("vec%0d_changed_before", v), 32'(o_changed), 32'(vecs[v].clr_at_commit));
      end
      i_chg_clr = 1'b0;
      chk($sformatf("vec%0d_changed_after", v), 32'(o_changed), 32'd1);
      chk($sformatf("vec%0d_state_after", v), 32'(o_state), 32'd0);
      chk($sformatf("vec%0d_wren_after", v), 32'(o_wren), 32'd0);
    end

    i_chg_clr = 1'b1;
    tick();
    i_chg_clr = 1'b0;
    chk("clear_alone", 32'(o_changed), 32'd0);

    // Bit 0 toggling every 5 cycles never survives the debounce window.
    seen_settle = 1'b0;
    seen_idle   = 1'b0;
    for (int c = 0; c < 100; c++) begin
      i_sw_raw = ((c / 5) % 2 == 1) ? 32'h1 : 32'h0;
      tick();
      chk("toggle_wren", 32'(o_wren), 32'd0);
      chk("toggle_not_commit", 32'(o_state == 2'd2), 32'd0);
      if (o_state == 2'd1) seen_settle = 1'b1;
      if (o_state == 2'd0) seen_idle   = 1'b1;
    end
    chk("toggle_saw_settle", 32'(seen_settle), 32'd1);
    chk("toggle_saw_idle",   32'(seen_idle),   32'd1);
    i_sw_raw = 32'h0;
    for (int c = 0; c < 4; c++) tick();
    chk("toggle_end_state",   32'(o_state),   32'd0);
    chk("toggle_end_changed", 32'(o_changed), 32'd0);

    // Short glitch to 1 and back: no write and comm must still be 0.
    i_sw_raw = 32'h1;
    for (int c = 0; c < 8; c++) tick();
    chk("glitch_in_settle", 32'(o_state), 32'd1);
    i_sw_raw = 32'h0;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("glitch_wren", 32'(o_wren), 32'd0);
      if (c >= 3) chk("glitch_idle", 32'(o_state), 32'd0);
    end
    chk("glitch_changed", 32'(o_changed), 32'd0);

    // Reset at cnt=10 aborts the pending commit; restart after release.
    i_sw_raw = 32'h0000_1234;
    for (int c = 0; c < 13; c++) tick();
    chk("rstab_settle", 32'(o_state), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstab_state", 32'(o_state), 32'd0);
    chk("rstab_wdata", o_wdata,      32'd0);
    chk("rstab_wren",  32'(o_wren),  32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rstab_hold_wren", 32'(o_wren), 32'd0);
    end
    rst_n = 1'b1;
    exp_q.push_back(32'h0000_1234);
    for (int t = 1; t <= 20; t++) begin
      tick();
      chk($sformatf("rstab_wren_e%0d", t), 32'(o_wren), 32'(t == 19));
    end
    chk("rstab_changed", 32'(o_changed), 32'd1);
    chk("rstab_final_state", 32'(o_state), 32'd0);

    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
